// File: rtl/bus_pkg.sv
// Shared constants and helpers for the CPU data-bus receive path.
package bus_pkg;

    localparam int unsigned BUS_WIDTH     = 8;
    localparam int unsigned RX_FIFO_DEPTH = 4;

    // Smallest r with 2**r >= value; elaboration-time sizing only.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module bus_fifo_mem
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned DEPTH = RX_FIFO_DEPTH,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_rx_fifo8.sv
// Samples the shared CPU data bus on bus_load and queues bytes for a valid/ready consumer.
module bus_rx_fifo8
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = BUS_WIDTH,
    parameter int unsigned DEPTH = RX_FIFO_DEPTH,
    localparam int unsigned CW   = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             ovf_clear
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          push, pop, drop;

    // Status comes only from the registered count, so no input reaches an output combinationally.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = ~empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign pop  = out_valid & out_ready;
    assign push = bus_load & (~full | pop);
    assign drop = bus_load & full & ~pop;

    assign wr_ptr_inc = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    assign rd_ptr_inc = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_inc;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            // A dropped load wins over a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clear) begin
                overflow_q <= 1'b0;
            end
        end
    end

    bus_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push & rst_n),
        .waddr(wr_ptr_q),
        .wdata(bus_in),
        .raddr(rd_ptr_q),
        .rdata(out_data)
    );

endmodule

// File: tb/tb_bus_rx_fifo8.sv
// Randomised and directed bench for bus_rx_fifo8 with a queue-based reference model.
module tb_bus_rx_fifo8;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] bus_in;
    logic             bus_load;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             ovf_clear;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    bit               run_mon = 1'b0;

    always #5 clk = ~clk;

    bus_rx_fifo8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_in   (bus_in),
        .bus_load (bus_load),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clear(ovf_clear)
    );

    always @(posedge clk) begin
        assert (!(rst_n === 1'b1 && bus_load === 1'b1 && $isunknown(bus_in)))
        else $error("bus_load asserted with unknown bits on bus_in");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a byte queue plus a sticky flag, updated from the inputs seen at each edge.
    task automatic model_loop();
        bit was_full, pop, push;
        forever begin
            @(posedge clk);
            if (rst_n !== 1'b1) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                was_full = (mq.size() == DEPTH);
                pop      = (mq.size() > 0) && (out_ready === 1'b1);
                push     = (bus_load === 1'b1) && (!was_full || pop);
                if (bus_load === 1'b1 && was_full && !pop) m_ovf = 1'b1;
                else if (ovf_clear === 1'b1) m_ovf = 1'b0;
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(bus_in);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (run_mon) begin
                check("mon_count", 32'(count), 32'(mq.size()));
                check("mon_empty", 32'(empty), 32'(mq.size() == 0));
                check("mon_full", 32'(full), 32'(mq.size() == DEPTH));
                check("mon_valid", 32'(out_valid), 32'(mq.size() != 0));
                check("mon_overflow", 32'(overflow), 32'(m_ovf));
                if (mq.size() > 0) check("mon_data", 32'(out_data), 32'(mq[0]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] b);
        bus_in   = b;
        bus_load = 1'b1;
        step();
        bus_load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_load  = 1'b1;
        bus_in    = 8'hFF;
        out_ready = 1'b0;
        ovf_clear = 1'b0;
        fork
            model_loop();
            monitor_loop();
            begin
                #2_000_000;
                $display("FAIL timeout: bench did not complete");
                $fatal(1, "timeout");
            end
        join_none

        // Reset held with a load pending
        for (int i = 0; i < 2; i++) begin
            step();
            run_mon = 1'b1;
            check("rst_count", 32'(count), 0);
            check("rst_empty", 32'(empty), 1);
            check("rst_valid", 32'(out_valid), 0);
            check("rst_overflow", 32'(overflow), 0);
        end
        rst_n    = 1'b1;
        bus_load = 1'b0;
        step();

        // Single byte
        load(8'hA5);
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h A5);
        check("single_count", 32'(count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_empty", 32'(empty), 1);

        // Fill and drain in order
        for (int i = 1; i <= 4; i++) load(8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 1);

        // Overflow on a full FIFO, then clear
        for (int i = 1; i <= 4; i++) load(8'(i));
        load(8'hEE);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 4);
        check("ovf_head", 32'(out_data), 32'h01);
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full pass-through: push and pop together
        check("pass_head", 32'(out_data), 32'h01);
        bus_in    = 8'h55;
        bus_load  = 1'b1;
        out_ready = 1'b1;
        step();
        bus_load  = 1'b0;
        out_ready = 1'b0;
        check("pass_count", 32'(count), 4);
        check("pass_overflow", 32'(overflow), 0);
        out_ready = 1'b1;
        check("pass_d0", 32'(out_data), 32'h02); step();
        check("pass_d1", 32'(out_data), 32'h03); step();
        check("pass_d2", 32'(out_data), 32'h04); step();
        check("pass_d3", 32'(out_data), 32'h55); step();
        out_ready = 1'b0;
        check("pass_empty", 32'(empty), 1);

        // Stream across pointer wrap, then a long random mix
        for (int i = 0; i < 10; i++) begin
            bus_in    = 8'($urandom);
            bus_load  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < 400; i++) begin
            bus_in    = 8'($urandom);
            bus_load  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            ovf_clear = ($urandom_range(0, 7) == 0);
            step();
        end
        bus_load  = 1'b0;
        ovf_clear = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) step();
        out_ready = 1'b0;
        check("wrap_empty", 32'(empty), 1);

        // Reset with three bytes queued
        load(8'h11);
        load(8'h22);
        load(8'h33);
        check("mid_count", 32'(count), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_empty", 32'(empty), 1);
        check("mid_rst_count", 32'(count), 0);
        load(8'h3C);
        check("post_rst_data", 32'(out_data), 32'h3C);
        check("post_rst_count", 32'(count), 1);
        step();

        run_mon = 1'b0;
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
